// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// Parametrised asynchronous serial transmitter with a one-entry holding
// register. A word is accepted on i_tx_valid & o_tx_ready. If the line is idle
// the word goes straight into the shift register and the start bit follows on
// the next cycle. Otherwise it waits in the holding register and is launched
// with no idle gap once the current frame's last stop bit ends.
//
// Frame: start(0) | DATA_BITS data, LSB first | [parity] | STOP_BITS stop(1)
// Every bit lasts CLKS_PER_BIT clock cycles.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   i_tx_data    in   word to send, sampled on handshake
//   i_tx_valid   in   word present
//   i_tx_break   in   (UART_TX_FRAME_BREAK_EN only) hold the line low when idle
//   o_tx_ready   out  holding register empty
//   o_tx_busy    out  frame on the line or word held
//   o_tx_data    out  serial line, idle high
//
// Build option
//   UART_TX_FRAME_BREAK_EN  adds i_tx_break and the line-break state. Without
//                           it there is no break port and no break logic.
//
// All outputs come straight from flops.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | line high, nothing in flight
// S_START  | start bit, line low
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit (unreachable when PARITY == 0)
// S_STOP   | stop bits, line high; also the recovery gap after a break
// S_BREAK  | (break build only) line held low while i_tx_break is high
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 2,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
`ifdef UART_TX_FRAME_BREAK_EN
    input  logic                 i_tx_break,
`endif
    output logic                 o_tx_ready,
    output logic                 o_tx_busy,
    output logic                 o_tx_data
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    // Elaboration-time parameter checks.
    if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
        $error("uart_tx_frame: CLKS_PER_BIT must be >= 1");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_FRAME_BREAK_EN
        , S_BREAK
`endif
    } state_e;

    state_e               state_q,    state_d;
    logic [CNT_W-1:0]     clk_cnt_q,  clk_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q,  bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 parity_q,   parity_d;
    logic [DATA_BITS-1:0] hold_q,     hold_d;
    logic                 hold_vld_q, hold_vld_d;
    logic                 tx_q,       tx_d;
    logic                 busy_q,     busy_d;
    logic                 ready_q,    ready_d;

    logic hs;
    logic bit_end;
    logic load_new;
    logic load_hold;
    logic brk;

`ifdef UART_TX_FRAME_BREAK_EN
    assign brk = i_tx_break;
`else
    assign brk = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        ready_d    = 1'b0;
        load_new   = 1'b0;
        load_hold  = 1'b0;

        hs      = i_tx_valid & ready_q;
        bit_end = (clk_cnt_q == '0);

        case (state_q)
            S_IDLE: begin
                // An accepted word wins over a break request raised on the
                // same edge; the break then waits for the frame to finish.
                if (hs) begin
                    load_new = 1'b1;
`ifdef UART_TX_FRAME_BREAK_EN
                end else if (brk) begin
                    state_d = S_BREAK;
`endif
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    clk_cnt_d = CNT_LOAD;
                    bit_idx_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q - 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    clk_cnt_d = CNT_LOAD;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q - 1'b1;
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    clk_cnt_d  = CNT_LOAD;
                    stop_idx_d = 1'b0;
                end else begin
                    clk_cnt_d = clk_cnt_q - 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == STOP_LAST) begin
                        // Last cycle of the last stop bit: chain the next
                        // frame directly if one is waiting or arriving now.
                        if (hold_vld_q) begin
                            load_hold = 1'b1;
                        end else if (hs) begin
                            load_new = 1'b1;
`ifdef UART_TX_FRAME_BREAK_EN
                        end else if (brk) begin
                            state_d = S_BREAK;
`endif
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                        clk_cnt_d  = CNT_LOAD;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q - 1'b1;
                end
            end

`ifdef UART_TX_FRAME_BREAK_EN
            S_BREAK: begin
                // Leaving a break reuses the stop-bit timing as the
                // mandatory high gap before any new start bit.
                if (!brk) begin
                    state_d    = S_STOP;
                    clk_cnt_d  = CNT_LOAD;
                    stop_idx_d = 1'b0;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_new) begin
            shift_d = i_tx_data;
        end else if (load_hold) begin
            shift_d    = hold_q;
            hold_vld_d = 1'b0;
        end

        if (load_new || load_hold) begin
            state_d   = S_START;
            clk_cnt_d = CNT_LOAD;
            // Parity is taken from the registered copy of the word, so later
            // changes on i_tx_data cannot disturb a frame in flight.
            parity_d  = (PARITY == 1) ? ~(^shift_d) : (^shift_d);
        end

        // Any handshake not consumed directly by the shift register lands in
        // the holding register; the transfer above has already freed it.
        if (hs && !load_new) begin
            hold_d     = i_tx_data;
            hold_vld_d = 1'b1;
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
`ifdef UART_TX_FRAME_BREAK_EN
            S_BREAK:  tx_d = 1'b0;
`endif
            default:  tx_d = 1'b1;
        endcase

        busy_d  = (state_d != S_IDLE) || hold_vld_d;
        ready_d = !hold_vld_d;
`ifdef UART_TX_FRAME_BREAK_EN
        if (brk && (state_d == S_IDLE || state_d == S_BREAK)) begin
            ready_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign o_tx_data  = tx_q;
    assign o_tx_busy  = busy_q;
    assign o_tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//
// Two transmitters with different frame formats:
//   dut_a: 8 data bits, even parity, 1 stop bit, 3 clocks per bit
//   dut_b: 7 data bits, odd parity, 2 stop bits, 1 clock per bit
// The reference model turns each accepted word into the list of line levels
// the frame should produce (one entry per clock) and appends it to a queue.
// Back-to-back frames are just concatenated lists, so gaps or reordering
// show up as line mismatches.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int A_CPB = 3;
    localparam int A_DB  = 8;
    localparam int A_PAR = 2;
    localparam int A_SB  = 1;

    localparam int B_CPB = 1;
    localparam int B_DB  = 7;
    localparam int B_PAR = 1;
    localparam int B_SB  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    logic [A_DB-1:0] data_a;
    logic            valid_a;
    logic            ready_a;
    logic            busy_a;
    logic            tx_a;

    logic [B_DB-1:0] data_b;
    logic            valid_b;
    logic            ready_b;
    logic            busy_b;
    logic            tx_b;

    uart_tx_frame #(
        .CLKS_PER_BIT(A_CPB),
        .DATA_BITS   (A_DB),
        .PARITY      (A_PAR),
        .STOP_BITS   (A_SB)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tx_data  (data_a),
        .i_tx_valid (valid_a),
        .o_tx_ready (ready_a),
        .o_tx_busy  (busy_a),
        .o_tx_data  (tx_a)
    );

    uart_tx_frame #(
        .CLKS_PER_BIT(B_CPB),
        .DATA_BITS   (B_DB),
        .PARITY      (B_PAR),
        .STOP_BITS   (B_SB)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tx_data  (data_b),
        .i_tx_valid (valid_b),
        .o_tx_ready (ready_b),
        .o_tx_busy  (busy_b),
        .o_tx_data  (tx_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0] words_q[$];
    logic       exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int w);
        return (w == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic get_ready(input int w);
        return (w == 0) ? ready_a : ready_b;
    endfunction

    function automatic int frame_len(input int w);
        if (w == 0) return (1 + A_DB + ((A_PAR != 0) ? 1 : 0) + A_SB) * A_CPB;
        return (1 + B_DB + ((B_PAR != 0) ? 1 : 0) + B_SB) * B_CPB;
    endfunction

    task automatic set_in(input int w, input logic v, input logic [8:0] d);
        if (w == 0) begin
            valid_a = v;
            data_a  = d[A_DB-1:0];
        end else begin
            valid_b = v;
            data_b  = d[B_DB-1:0];
        end
    endtask

    // Append the per-clock line levels of one frame to exp_q.
    task automatic push_frame(input int w, input logic [8:0] word);
        int nb;
        int par;
        int sb;
        int cpb;
        int ones;
        int b;
        int pb;
        nb   = (w == 0) ? A_DB  : B_DB;
        par  = (w == 0) ? A_PAR : B_PAR;
        sb   = (w == 0) ? A_SB  : B_SB;
        cpb  = (w == 0) ? A_CPB : B_CPB;
        ones = 0;
        for (int k = 0; k < cpb; k++) exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            b = (int'(word) >> i) % 2;
            ones += b;
            for (int k = 0; k < cpb; k++) exp_q.push_back(b[0]);
        end
        if (par != 0) begin
            pb = (par == 2) ? (ones % 2) : (1 - ones % 2);
            for (int k = 0; k < cpb; k++) exp_q.push_back(pb[0]);
        end
        for (int k = 0; k < sb * cpb; k++) exp_q.push_back(1'b1);
    endtask

    // Send everything in words_q through transmitter w and check the line,
    // busy and ready every cycle. Call at a falling edge with the DUT idle.
    // gaps=0: valid held high (back-to-back). gaps=1: random valid gaps, and
    // junk data with valid high whenever ready is low.
    task automatic run_stream(input int w, input bit gaps, input string tag);
        int budget;
        int flen;
        flen   = frame_len(w);
        budget = (words_q.size() + 2) * flen * 4 + 50;
        exp_q.delete();
        while ((words_q.size() != 0 || exp_q.size() != 0) && budget > 0) begin
            chk({tag, " busy"},  32'(get_busy(w)),  32'(exp_q.size() != 0));
            chk({tag, " ready"}, 32'(get_ready(w)), 32'(exp_q.size() <= flen));
            if (exp_q.size() != 0) chk({tag, " line"}, 32'(get_tx(w)), 32'(exp_q.pop_front()));
            else                   chk({tag, " idle line"}, 32'(get_tx(w)), 32'd1);

            if (words_q.size() != 0 && (!gaps || $urandom_range(3) != 0)) begin
                set_in(w, 1'b1, words_q[0]);
                if (get_ready(w)) push_frame(w, words_q.pop_front());
            end else if (gaps && !get_ready(w)) begin
                set_in(w, 1'b1, 9'($urandom));
            end else begin
                set_in(w, 1'b0, 9'($urandom));
            end
            budget--;
            @(negedge clk);
        end
        set_in(w, 1'b0, 9'd0);
        chk({tag, " within budget"}, 32'(budget > 0), 32'd1);
        chk({tag, " busy after"},    32'(get_busy(w)), 32'd0);
        chk({tag, " line after"},    32'(get_tx(w)),   32'd1);
        words_q.delete();
    endtask

    // Start a frame on dut_a, hold a second word, reset mid-DATA, then verify
    // the line is released at once and the held word never appears.
    task automatic reset_mid(input logic [8:0] word, input string tag);
        int flen;
        flen = frame_len(0);
        exp_q.delete();
        chk({tag, " ready pre"}, 32'(ready_a), 32'd1);
        set_in(0, 1'b1, word);
        push_frame(0, word);
        @(negedge clk);
        chk({tag, " line"}, 32'(tx_a), 32'(exp_q.pop_front()));
        set_in(0, 1'b1, 9'($urandom));
        @(negedge clk);
        set_in(0, 1'b0, 9'd0);
        chk({tag, " line"}, 32'(tx_a), 32'(exp_q.pop_front()));
        chk({tag, " ready held"}, 32'(ready_a), 32'd0);
        repeat (A_CPB * 3) begin
            @(negedge clk);
            chk({tag, " line"}, 32'(tx_a), 32'(exp_q.pop_front()));
        end
        #2 rst_n = 1'b0;
        #1;
        chk({tag, " rst line"},  32'(tx_a),    32'd1);
        chk({tag, " rst busy"},  32'(busy_a),  32'd0);
        chk({tag, " rst ready"}, 32'(ready_a), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk({tag, " rst ready hold"}, 32'(ready_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, " ready release"}, 32'(ready_a), 32'd1);
        for (int i = 0; i < 2 * flen; i++) begin
            chk({tag, " quiet line"}, 32'(tx_a),   32'd1);
            chk({tag, " quiet busy"}, 32'(busy_a), 32'd0);
            @(negedge clk);
        end
        exp_q.delete();
    endtask

    initial begin
        set_in(0, 1'b0, 9'd0);
        set_in(1, 1'b0, 9'd0);

        #1 rst_n = 1'b0;
        #1;
        chk("reset a line",  32'(tx_a),    32'd1);
        chk("reset a busy",  32'(busy_a),  32'd0);
        chk("reset a ready", 32'(ready_a), 32'd0);
        chk("reset b line",  32'(tx_b),    32'd1);
        chk("reset b busy",  32'(busy_b),  32'd0);
        chk("reset b ready", 32'(ready_b), 32'd0);
        repeat (2) @(negedge clk);
        chk("reset a ready clocked", 32'(ready_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release a ready", 32'(ready_a), 32'd1);
        chk("release b ready", 32'(ready_b), 32'd1);

        words_q = '{9'h055};
        run_stream(0, 1'b0, "a single 55");

        words_q = '{9'h007, 9'h003};
        run_stream(0, 1'b0, "a parity 07 03");

        words_q = '{9'h0A1, 9'h0B2, 9'h0C3};
        run_stream(0, 1'b0, "a b2b A1 B2 C3");

        for (int i = 0; i < 6; i++) words_q.push_back(9'($urandom));
        run_stream(0, 1'b0, "a b2b random");

        for (int i = 0; i < 8; i++) words_q.push_back(9'($urandom));
        run_stream(0, 1'b1, "a gaps random");

        words_q = '{9'h000};
        run_stream(1, 1'b0, "b single 00");

        words_q = '{9'h000, 9'h17F, 9'h080};
        run_stream(1, 1'b0, "b b2b edge words");

        for (int i = 0; i < 8; i++) words_q.push_back(9'($urandom));
        run_stream(1, 1'b0, "b b2b random");

        for (int i = 0; i < 8; i++) words_q.push_back(9'($urandom));
        run_stream(1, 1'b1, "b gaps random");

        reset_mid(9'h0FF, "a reset FF");
        words_q = '{9'h03C};
        run_stream(0, 1'b0, "a after reset 3C");

        reset_mid(9'h000, "a reset 00");
        for (int i = 0; i < 4; i++) words_q.push_back(9'($urandom));
        run_stream(0, 1'b1, "a after reset random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
